// File: rtl/logc_pkg.sv
// Shared constants and helper functions for the multi-channel log compressor.
package logc_pkg;

  localparam int DEF_DATA_WIDTH    = 48;
  localparam int DEF_FRAC_WIDTH    = 16;
  localparam int DEF_MIN_THRESHOLD = 1;

  // Widest sample the leading-one helper accepts; narrower samples are zero-extended.
  localparam int LOD_WIDTH = 64;

  // Width needed to index n items, never less than one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Index of the most significant set bit; returns 0 for a zero input.
  function automatic int lod(input logic [LOD_WIDTH-1:0] x);
    int idx;
    idx = 0;
    for (int i = 0; i < LOD_WIDTH; i++) begin
      if (x[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/logc_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above rr_ptr, wrapping,
// and moves rr_ptr past the granted channel when the grant is used.
module logc_rr_arb
  import logc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CH_WIDTH = clog2_safe(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   req,
  input  logic                advance,
  output logic [NUM_CH-1:0]   grant,
  output logic [CH_WIDTH-1:0] grant_idx
);

  logic [CH_WIDTH-1:0] r_rr_ptr;

  // Pick the lowest requester at/above rr_ptr, else the lowest requester overall.
  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
    grant_idx = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (req[c]) grant_idx = CH_WIDTH'(c);
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (req[c] && (CH_WIDTH'(c) >= r_rr_ptr)) grant_idx = CH_WIDTH'(c);
    end
    grant = (|req) ? (NUM_CH'(1) << grant_idx) : '0;
  end

  // Advance the pointer past the channel that was just served.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (advance) begin
      r_rr_ptr <= (grant_idx == CH_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/logc_mc.sv
// Multi-channel Mitchell log2 compressor: round-robin admission into a shared
// three-stage pipeline (clamp, leading-one detect, normalise) with a
// backpressured, channel-tagged output and a saturating clamp counter.
module logc_mc
  import logc_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int FRAC_WIDTH    = DEF_FRAC_WIDTH,
  parameter int NUM_CH        = 4,
  parameter int MIN_THRESHOLD = DEF_MIN_THRESHOLD,
  parameter int SHIFT_WIDTH   = $clog2(DATA_WIDTH),
  parameter int CH_WIDTH      = clog2_safe(NUM_CH),
  parameter int CNT_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_WIDTH-1:0]          out_ch,
  output logic [SHIFT_WIDTH-1:0]       out_int,
  output logic [FRAC_WIDTH-1:0]        out_frac,
  output logic                         out_clamped,
  output logic [CNT_WIDTH-1:0]         clamp_count,
  input  logic                         clamp_clr
);

  localparam logic [DATA_WIDTH-1:0] MIN_X = DATA_WIDTH'(MIN_THRESHOLD);

  logic                  w_pipe_en;
  logic                  w_accept;
  logic [NUM_CH-1:0]     w_grant;
  logic [CH_WIDTH-1:0]   w_grant_idx;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_below;

  logic                   r_s1_valid, r_s2_valid, r_s3_valid;
  logic [CH_WIDTH-1:0]    r_s1_ch, r_s2_ch, r_out_ch;
  logic [DATA_WIDTH-1:0]  r_s1_x, r_s2_x;
  logic                   r_s1_clamped, r_s2_clamped, r_out_clamped;
  logic [SHIFT_WIDTH-1:0] r_s2_int, r_out_int;
  logic [FRAC_WIDTH-1:0]  r_out_frac;
  logic [CNT_WIDTH-1:0]   r_clamp_count;

  logic [SHIFT_WIDTH-1:0]           w_shift;
  logic [DATA_WIDTH-2:0]            w_norm;
  logic [DATA_WIDTH-2+FRAC_WIDTH:0] w_frac_ext;
  logic [FRAC_WIDTH-1:0]            w_frac;

  // The whole pipeline moves unless a finished result is waiting on the consumer.
  assign w_pipe_en = !r_s3_valid || out_ready;
  assign w_accept  = (|in_valid) && w_pipe_en && !reset;
  assign in_ready  = reset ? '0 : (w_grant & {NUM_CH{w_pipe_en}});

  logc_rr_arb #(
    .NUM_CH   (NUM_CH),
    .CH_WIDTH (CH_WIDTH)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (w_accept),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // Select the granted channel's sample.
  always_comb begin
    w_sel_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_grant[c]) w_sel_data = in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_below = (w_sel_data < MIN_X);

  // Normalise: shift the leading one to the top; the bits below it are the mantissa.
  assign w_shift    = SHIFT_WIDTH'(DATA_WIDTH - 1) - r_s2_int;
  assign w_norm     = (DATA_WIDTH-1)'(r_s2_x << w_shift);
  assign w_frac_ext = {w_norm, {FRAC_WIDTH{1'b0}}};
  assign w_frac     = FRAC_WIDTH'(w_frac_ext >> (DATA_WIDTH - 1));

  // Stage-valid flags advance together whenever the pipeline is enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (w_pipe_en) begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // S1 clamp/capture and S2 leading-one detect.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are qualified by the valid flags, so they carry no reset.
    if (w_pipe_en) begin
      r_s1_ch      <= w_grant_idx;
      r_s1_x       <= w_below ? MIN_X : w_sel_data;
      r_s1_clamped <= w_below;
      r_s2_ch      <= r_s1_ch;
      r_s2_x       <= r_s1_x;
      r_s2_int     <= SHIFT_WIDTH'(lod(LOD_WIDTH'(r_s1_x)));
      r_s2_clamped <= r_s1_clamped;
    end
  end

  // S3 output registers; they only change when a valid result moves in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_ch      <= '0;
      r_out_int     <= '0;
      r_out_frac    <= '0;
      r_out_clamped <= 1'b0;
    end else if (w_pipe_en && r_s2_valid) begin
      r_out_ch      <= r_s2_ch;
      r_out_int     <= r_s2_int;
      r_out_frac    <= w_frac;
      r_out_clamped <= r_s2_clamped;
    end
  end

  // Count clamped results as they are handed off; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clamp_count <= '0;
    end else if (clamp_clr) begin
      r_clamp_count <= '0;
    end else if (r_s3_valid && out_ready && r_out_clamped && (r_clamp_count != '1)) begin
      r_clamp_count <= r_clamp_count + 1'b1;
    end
  end

  assign out_valid   = r_s3_valid;
  assign out_ch      = r_out_ch;
  assign out_int     = r_out_int;
  assign out_frac    = r_out_frac;
  assign out_clamped = r_out_clamped;
  assign clamp_count = r_clamp_count;

endmodule

// File: tb/tb_logc_mc.sv
// Self-checking bench for logc_mc: scoreboard fed at input acceptance and
// drained at output handshakes, plus a second instance (MIN_THRESHOLD=256,
// 4-bit counter) for clamping and counter saturation.
module tb_logc_mc;

  localparam int DW = 48;
  localparam int NC = 4;
  localparam logic [DW-1:0] TB_MIN = 48'd1;

  typedef struct {
    logic [1:0]  ch;
    logic [5:0]  ipart;
    logic [15:0] frac;
    logic        clamped;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, out_ready, clamp_clr;
  logic [NC-1:0]    in_valid, in_ready;
  logic [NC*DW-1:0] in_data;
  logic             out_valid, out_clamped;
  logic [1:0]       out_ch;
  logic [5:0]       out_int;
  logic [15:0]      out_frac, clamp_count;

  logic             t2_out_ready, t2_clamp_clr;
  logic [NC-1:0]    t2_in_valid, t2_in_ready;
  logic [NC*DW-1:0] t2_in_data;
  logic             t2_out_valid, t2_out_clamped;
  logic [1:0]       t2_out_ch;
  logic [5:0]       t2_out_int;
  logic [15:0]      t2_out_frac;
  logic [3:0]       t2_clamp_count;

  logc_mc u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_int(out_int),
    .out_frac(out_frac), .out_clamped(out_clamped), .clamp_count(clamp_count), .clamp_clr(clamp_clr)
  );

  logc_mc #(.MIN_THRESHOLD(256), .CNT_WIDTH(4)) u_dut_thr (
    .clk(clk), .reset(reset), .in_valid(t2_in_valid), .in_data(t2_in_data), .in_ready(t2_in_ready),
    .out_valid(t2_out_valid), .out_ready(t2_out_ready), .out_ch(t2_out_ch), .out_int(t2_out_int),
    .out_frac(t2_out_frac), .out_clamped(t2_out_clamped), .clamp_count(t2_clamp_count),
    .clamp_clr(t2_clamp_clr)
  );

  res_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t mk(input int ch, input int ip, input logic [15:0] f, input logic c);
    res_t r;
    r.ch = 2'(ch); r.ipart = 6'(ip); r.frac = f; r.clamped = c;
    return r;
  endfunction

  // Reference: arithmetic form of Mitchell's mantissa, (x - 2^msb) * 2^16 / 2^msb.
  function automatic res_t model(input logic [DW-1:0] x, input int ch);
    res_t r;
    logic [63:0] xc, m;
    int msb;
    xc  = (x < TB_MIN) ? 64'(TB_MIN) : 64'(x);
    msb = 0;
    for (int i = 0; i < DW; i++) if (xc[i]) msb = i;
    m = ((xc - (64'd1 << msb)) << 16) >> msb;
    r.ch = 2'(ch); r.ipart = 6'(msb); r.frac = m[15:0]; r.clamped = (x < TB_MIN);
    return r;
  endfunction

  task automatic send_exp(input int ch, input logic [DW-1:0] x, input res_t e);
    bit done = 1'b0;
    in_data[ch*DW +: DW] = x;
    in_valid[ch] = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready[ch]) begin
        sb.push_back(e);
        done = 1'b1;
      end
    end
    check("accept", 64'(done), 64'd1);
    @(posedge clk); #1;
    in_valid[ch] = 1'b0;
  endtask

  task automatic send(input int ch, input logic [DW-1:0] x);
    send_exp(ch, x, model(x, ch));
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (sb.size() == 0) ok = 1'b1;
    end
    check("drain", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        res_t e;
        e = sb.pop_front();
        check("out_ch", 64'(out_ch), 64'(e.ch));
        check("out_int", 64'(out_int), 64'(e.ipart));
        check("out_frac", 64'(out_frac), 64'(e.frac));
        check("out_clamped", 64'(out_clamped), 64'(e.clamped));
      end
    end
  end

  // At most one in_ready bit may ever be high.
  always @(negedge clk) check("in_ready_onehot0", 64'($onehot0(in_ready)), 64'd1);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] v4[4];
  logic [DW-1:0] bp[8];

  initial begin
    v4 = '{48'd10, 48'd20, 48'd30, 48'd40};
    bp = '{48'd5, 48'd100, 48'd1000, 48'd77777, 48'd12345678, 48'd3, 48'h100_0000_0005, 48'd999};
    reset = 1'b1; out_ready = 1'b1; clamp_clr = 1'b0;
    in_valid = '1; in_data = '0;
    t2_in_valid = '0; t2_in_data = '0; t2_out_ready = 1'b1; t2_clamp_clr = 1'b0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_fields", 64'({out_ch, out_int, out_frac, out_clamped}), 64'd0);
    check("rst_clamp_count", 64'(clamp_count), 64'd0);
    in_valid = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // First sample and its latency.
    send_exp(0, 48'd987654321, mk(0, 29, 16'd55027, 1'b0));
    check("lat_t1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_t2", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_t3", 64'(out_valid), 64'd1);
    wait_drain();

    // Channel 1 directed values including clamp of zero.
    send_exp(1, 48'd120362, mk(1, 16, 16'd54826, 1'b0));
    send_exp(1, 48'd65536,  mk(1, 16, 16'd0, 1'b0));
    send_exp(1, 48'd1,      mk(1, 0, 16'd0, 1'b0));
    send_exp(1, 48'd0,      mk(1, 0, 16'd0, 1'b1));
    wait_drain();
    check("clamp_count_1", 64'(clamp_count), 64'd1);

    // Top-of-range sample on channel 3 (pointer wraps to 0 afterwards).
    send_exp(3, 48'hFFFF_FFFF_FFFF, mk(3, 47, 16'hFFFF, 1'b0));
    wait_drain();

    // All channels requesting: strict rotation 0,1,2,3,0,...
    for (int c = 0; c < NC; c++) in_data[c*DW +: DW] = v4[c];
    in_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(in_ready), 64'(4'b0001 << (k % NC)));
      sb.push_back(model(v4[k % NC], k % NC));
    end
    @(posedge clk); #1;
    in_valid = '0;
    wait_drain();

    // Backpressure mid-stream on channel 2.
    for (int k = 0; k < 4; k++) send(2, bp[k]);
    in_data[2*DW +: DW] = bp[4];
    in_valid[2] = 1'b1;
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_sb_depth", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        check("stall_out_ch", 64'(out_ch), 64'(sb[0].ch));
        check("stall_out_int", 64'(out_int), 64'(sb[0].ipart));
        check("stall_out_frac", 64'(out_frac), 64'(sb[0].frac));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 4; k < 8; k++) send(2, bp[k]);
    wait_drain();

    // Reset with three samples in flight.
    send(0, 48'd500);
    send(0, 48'd600);
    send(0, 48'd700);
    check("inflight_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_clamp_count", 64'(clamp_count), 64'd0);
    check("async_out_fields", 64'({out_ch, out_int, out_frac, out_clamped}), 64'd0);
    @(posedge clk); #1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("no_stale_output", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    in_data[0 +: DW] = 48'd42;
    in_data[DW +: DW] = 48'd43;
    in_valid = 4'b0011;
    @(negedge clk);
    check("rr_ptr_reset", 64'(in_ready), 64'd1);
    sb.push_back(model(48'd42, 0));
    @(posedge clk); #1;
    in_valid = '0;
    wait_drain();

    // Threshold instance: clamp to 256, counter saturation and clear priority.
    begin
      bit got = 1'b0;
      t2_in_data[0 +: DW] = 48'd255;
      t2_in_valid = 4'b0001;
      for (int n = 0; n < 10 && !got; n++) begin
        @(negedge clk);
        if (t2_out_valid) got = 1'b1;
      end
      check("t2_first_out", 64'(got), 64'd1);
      check("t2_out_ch", 64'(t2_out_ch), 64'd0);
      check("t2_out_int", 64'(t2_out_int), 64'd8);
      check("t2_out_frac", 64'(t2_out_frac), 64'd0);
      check("t2_out_clamped", 64'(t2_out_clamped), 64'd1);
      repeat (20) @(negedge clk);
      check("t2_saturated", 64'(t2_clamp_count), 64'hF);
      @(negedge clk);
      check("t2_sat_hold", 64'(t2_clamp_count), 64'hF);
      @(posedge clk); #1;
      t2_clamp_clr = 1'b1;
      @(negedge clk);
      check("t2_coincident_inc", 64'(t2_out_valid && t2_out_ready && t2_out_clamped), 64'd1);
      @(posedge clk); #1;
      check("t2_clr_priority", 64'(t2_clamp_count), 64'd0);
      t2_clamp_clr = 1'b0;
      @(posedge clk); #1;
      check("t2_count_resume", 64'(t2_clamp_count), 64'd1);
      t2_in_valid = '0;
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
